ram_port_arbiter: RTL and testbench

- Shares the single-port RAM's 10-bit command interface between two requesters: the SPI slave and a local host port.
- RAM command words carry a command in din[9:8]: 00 write-address, 01 write-data, 10 read-address, 11 read-data. A returned byte comes back with tx_valid.
- The RAM holds its address internally, so an address word and the data word that follows it must not be interleaved with another requester's traffic. This block serialises requests, locks the grant across each address/data pair, routes read data back to the owner, and bounds every wait with a timeout.

---
 rtl/ram_port_arbiter.sv | 158 +++++++++++++++
 tb/tb_ram_port_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter for the RAM's 10-bit command port.
// Locks the grant across address/data pairs and returns read bytes to the owner.
module ram_port_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] req0_data,
    input  logic       req0_valid,
    output logic       req0_ready,
    output logic [7:0] req0_dout,
    output logic       req0_dout_valid,
    input  logic [9:0] req1_data,
    input  logic       req1_valid,
    output logic       req1_ready,
    output logic [7:0] req1_dout,
    output logic       req1_dout_valid,
    output logic [9:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic [1:0] grant,
    output logic       timeout_err
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        LOCKED,
        WAIT_RD
    } state_t;

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic       ptr_q, ptr_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] grant_d;
    logic [9:0] rx_data_d;
    logic       rx_valid_d;
    logic [1:0] ready_d;
    logic [1:0] dv_d;
    logic [7:0] dout0_d, dout1_d;
    logic       to_d;
    logic       rel;

    logic       v0, v1;
    logic       owner;
    logic       own_valid;
    logic [9:0] own_data;
    logic       pick;

    // A word whose ready is still high was already consumed.
    assign v0        = req0_valid & ~req0_ready;
    assign v1        = req1_valid & ~req1_ready;
    assign owner     = grant[1];
    assign own_valid = owner ? v1 : v0;
    assign own_data  = owner ? req1_data : req0_data;
    assign pick      = (v0 & v1) ? ptr_q : v1;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        grant_d    = grant;
        rx_data_d  = rx_data;
        rx_valid_d = 1'b0;
        ready_d    = 2'b00;
        dv_d       = 2'b00;
        dout0_d    = req0_dout;
        dout1_d    = req1_dout;
        to_d       = 1'b0;
        rel        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (v0 | v1) begin
                    grant_d = pick ? 2'b10 : 2'b01;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                rx_data_d      = own_data;
                rx_valid_d     = 1'b1;
                ready_d[owner] = 1'b1;
                cnt_d          = 8'd0;
                unique case (own_data[9:8])
                    2'b00, 2'b10: state_d = LOCKED;
                    2'b01:        rel     = 1'b1;
                    default:      state_d = WAIT_RD;
                endcase
            end
            LOCKED: begin
                cnt_d = cnt_q + 8'd1;
                if (own_valid) begin
                    state_d = ISSUE;
                    cnt_d   = 8'd0;
                end else if (cnt_q == LAST) begin
                    to_d = 1'b1;
                    rel  = 1'b1;
                end
            end
            WAIT_RD: begin
                cnt_d = cnt_q + 8'd1;
                // Data arriving on the last cycle still beats the timeout.
                if (tx_valid) begin
                    dv_d[owner] = 1'b1;
                    if (owner) dout1_d = tx_data;
                    else       dout0_d = tx_data;
                    rel = 1'b1;
                end else if (cnt_q == LAST) begin
                    to_d = 1'b1;
                    rel  = 1'b1;
                end
            end
        endcase

        if (rel) begin
            grant_d = 2'b00;
            ptr_d   = ~owner;
            cnt_d   = 8'd0;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            ptr_q           <= 1'b0;
            cnt_q           <= 8'd0;
            grant           <= 2'b00;
            rx_data         <= 10'd0;
            rx_valid        <= 1'b0;
            req0_ready      <= 1'b0;
            req1_ready      <= 1'b0;
            req0_dout       <= 8'd0;
            req1_dout       <= 8'd0;
            req0_dout_valid <= 1'b0;
            req1_dout_valid <= 1'b0;
            timeout_err     <= 1'b0;
        end else begin
            state_q         <= state_d;
            ptr_q           <= ptr_d;
            cnt_q           <= cnt_d;
            grant           <= grant_d;
            rx_data         <= rx_data_d;
            rx_valid        <= rx_valid_d;
            req0_ready      <= ready_d[0];
            req1_ready      <= ready_d[1];
            req0_dout       <= dout0_d;
            req1_dout       <= dout1_d;
            req0_dout_valid <= dv_d[0];
            req1_dout_valid <= dv_d[1];
            timeout_err     <= to_d;
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: vector table plus
// hand-written timeout, contention and reset sequences.
module tb_ram_port_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] req0_data, req1_data;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [7:0] req0_dout, req1_dout;
    logic       req0_dout_valid, req1_dout_valid;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic [1:0] grant;
    logic       timeout_err;

    ram_port_arbiter #(.TIMEOUT(16)) dut (
        .clk(clk),
        .rst(rst),
        .req0_data(req0_data),
        .req0_valid(req0_valid),
        .req0_ready(req0_ready),
        .req0_dout(req0_dout),
        .req0_dout_valid(req0_dout_valid),
        .req1_data(req1_data),
        .req1_valid(req1_valid),
        .req1_ready(req1_ready),
        .req1_dout(req1_dout),
        .req1_dout_valid(req1_dout_valid),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .grant(grant),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int to_cnt = 0;

    logic [9:0] exp_rx[$];
    logic [7:0] exp_d0[$];
    logic [7:0] exp_d1[$];

    typedef struct {
        int         r;
        logic [9:0] w0;
        logic [9:0] w1;
        int         lat;
        logic [7:0] rd;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    function automatic logic [1:0] oh(input int r);
        return (r != 0) ? 2'b10 : 2'b01;
    endfunction

    // Scoreboard: every strobe from the DUT must match the next expected item.
    always @(negedge clk) begin
        if (timeout_err) to_cnt++;
        if (rx_valid) begin
            if (exp_rx.size() == 0) begin
                total++;
                $display("FAIL rx_extra: got 0x%0h, required no word", rx_data);
            end else check("rx_word", rx_data, exp_rx.pop_front());
        end
        if (req0_dout_valid) begin
            if (exp_d0.size() == 0) begin
                total++;
                $display("FAIL d0_extra: got 0x%0h, required no byte", req0_dout);
            end else check("d0_byte", req0_dout, exp_d0.pop_front());
        end
        if (req1_dout_valid) begin
            if (exp_d1.size() == 0) begin
                total++;
                $display("FAIL d1_extra: got 0x%0h, required no byte", req1_dout);
            end else check("d1_byte", req1_dout, exp_d1.pop_front());
        end
    end

    task automatic send(input int r, input logic [9:0] w);
        bit seen;
        seen = 1'b0;
        if (r == 0) begin
            req0_data  = w;
            req0_valid = 1'b1;
        end else begin
            req1_data  = w;
            req1_valid = 1'b1;
        end
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge clk);
            seen = (r == 0) ? req0_ready : req1_ready;
        end
        if (r == 0) req0_valid = 1'b0;
        else        req1_valid = 1'b0;
        if (!seen) begin
            total++;
            $display("FAIL ready_wait: req%0d word 0x%0h got no ready, required one", r, w);
        end
    endtask

    task automatic pulse_tx(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    int to0;

    initial begin
        vecs[0] = '{0, 10'h005, 10'h1A5, 0, 8'h00};
        vecs[1] = '{1, 10'h205, 10'h300, 3, 8'hA5};
        vecs[2] = '{0, 10'h210, 10'h3FF, 1, 8'h3C};
        vecs[3] = '{1, 10'h0FF, 10'h100, 0, 8'h00};
        vecs[4] = '{0, 10'h2AA, 10'h355, 15, 8'hFF};

        rst        = 1'b1;
        req0_data  = '0;
        req1_data  = '0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tx_data    = '0;
        tx_valid   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_grant", grant, 2'b00);
        check("rst_strobes", {rx_valid, req0_ready, req1_ready, timeout_err,
              req0_dout_valid, req1_dout_valid}, 6'd0);
        check("rst_data", {rx_data, req0_dout, req1_dout}, 26'd0);
        rst = 1'b0;

        // Contention: req0 wins from ptr=0 and keeps the lock over its pair.
        exp_rx.push_back(10'h005);
        exp_rx.push_back(10'h1A5);
        exp_rx.push_back(10'h206);
        exp_rx.push_back(10'h1B6);
        fork
            begin
                send(0, 10'h005);
                send(0, 10'h1A5);
            end
            begin
                send(1, 10'h206);
                check("cont_grant_req1", grant, 2'b10);
                send(1, 10'h1B6);
            end
        join
        repeat (3) @(negedge clk);
        check("cont_drained", exp_rx.size(), 0);

        for (int i = 0; i < 5; i++) begin
            to0 = to_cnt;
            exp_rx.push_back(vecs[i].w0);
            exp_rx.push_back(vecs[i].w1);
            if (vecs[i].w1[9:8] == 2'b11) begin
                if (vecs[i].r == 0) exp_d0.push_back(vecs[i].rd);
                else                exp_d1.push_back(vecs[i].rd);
            end
            send(vecs[i].r, vecs[i].w0);
            check($sformatf("v%0d_grant_lock", i), grant, oh(vecs[i].r));
            send(vecs[i].r, vecs[i].w1);
            check($sformatf("v%0d_grant_w1", i), grant,
                  (vecs[i].w1[9:8] == 2'b11) ? oh(vecs[i].r) : 2'b00);
            if (vecs[i].w1[9:8] == 2'b11) begin
                repeat (vecs[i].lat) @(negedge clk);
                pulse_tx(vecs[i].rd);
            end
            repeat (3) @(negedge clk);
            check($sformatf("v%0d_grant_end", i), grant, 2'b00);
            check($sformatf("v%0d_ptr", i), dut.ptr_q, 1 - vecs[i].r);
            check($sformatf("v%0d_no_timeout", i), to_cnt, to0);
            check($sformatf("v%0d_drained", i),
                  exp_rx.size() + exp_d0.size() + exp_d1.size(), 0);
            if (vecs[i].w1[9:8] == 2'b11)
                check($sformatf("v%0d_dout", i),
                      (vecs[i].r == 0) ? req0_dout : req1_dout, vecs[i].rd);
        end

        // Lock timeout with req1 waiting behind the lock.
        exp_rx.push_back(10'h007);
        exp_rx.push_back(10'h206);
        exp_rx.push_back(10'h1C6);
        fork
            begin
                send(0, 10'h007);
                repeat (15) @(negedge clk);
                check("lock_to_early", timeout_err, 1'b0);
                check("lock_grant_held", grant, 2'b01);
                @(negedge clk);
                check("lock_to_pulse", timeout_err, 1'b1);
                check("lock_grant_rel", grant, 2'b00);
                @(negedge clk);
                check("lock_to_width", timeout_err, 1'b0);
                check("lock_next_req1", grant, 2'b10);
            end
            begin
                repeat (2) @(negedge clk);
                send(1, 10'h206);
                send(1, 10'h1C6);
            end
        join
        repeat (3) @(negedge clk);
        check("lock_ptr", dut.ptr_q, 1'b0);
        check("lock_drained", exp_rx.size(), 0);

        // Read timeout, then a stray tx_valid in IDLE.
        exp_rx.push_back(10'h205);
        exp_rx.push_back(10'h300);
        send(1, 10'h205);
        send(1, 10'h300);
        repeat (15) @(negedge clk);
        check("rd_to_early", timeout_err, 1'b0);
        check("rd_grant_held", grant, 2'b10);
        @(negedge clk);
        check("rd_to_pulse", {timeout_err, grant, req1_dout_valid}, 4'b1000);
        @(negedge clk);
        pulse_tx(8'h77);
        repeat (3) @(negedge clk);
        check("rd_to_dout_hold", req1_dout, 8'hA5);
        check("rd_to_drained", exp_rx.size() + exp_d1.size(), 0);

        // Reset while waiting for read data, with ptr=1 beforehand.
        exp_rx.push_back(10'h133);
        send(0, 10'h133);
        repeat (2) @(negedge clk);
        check("pre_rst_ptr", dut.ptr_q, 1'b1);
        exp_rx.push_back(10'h204);
        exp_rx.push_back(10'h304);
        send(0, 10'h204);
        send(0, 10'h304);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_grant", grant, 2'b00);
        check("mid_rst_douts", {req0_dout, req1_dout}, 16'd0);
        check("mid_rst_rest", {rx_data, rx_valid, req0_ready, req1_ready,
              req0_dout_valid, req1_dout_valid, timeout_err}, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        to0 = to_cnt;
        pulse_tx(8'h99);
        repeat (2) @(negedge clk);
        exp_rx.push_back(10'h144);
        exp_rx.push_back(10'h155);
        fork
            send(0, 10'h144);
            send(1, 10'h155);
        join
        repeat (3) @(negedge clk);
        check("post_rst_drained",
              exp_rx.size() + exp_d0.size() + exp_d1.size(), 0);
        check("post_rst_grant", grant, 2'b00);
        check("post_rst_no_timeout", to_cnt, to0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
